ser6_rx_deser: RTL and testbench

//  Serial-to-parallel receiver that assembles a framed 6-bit word from a single-wire line.

---
 rtl/ser6_pkg.sv | 23 ++
 rtl/sync_2ff.sv | 25 ++
 rtl/ser6_rx_deser.sv | 147 ++++++++++++++
 tb/tb_ser6_rx_deser.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/ser6_pkg.sv
// Shared types and defaults for the 6-bit serial receive path.
// Also holds the even-parity helper used when checking the received word.
package ser6_pkg;

    localparam int WIDTH_DEF = 6;
    localparam int CPB_DEF   = 4;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        BREAK  = 3'd5
    } state_t;

    // Returns 1 when the word has an odd number of ones, which is the
    // parity bit an even-parity transmitter appends.
    function automatic logic even_parity(input logic [WIDTH_DEF-1:0] word);
        return ^word;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous inputs.
// The reset value is a parameter so idle-high lines stay idle through reset.
module sync_2ff #(
    parameter int           WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/ser6_rx_deser.sv
// Framed serial receiver: start bit, 6 data bits LSB first, optional even
// parity, stop bit. Feeds the I input of the downstream 6-bit register.
module ser6_rx_deser
    import ser6_pkg::*;
#(
    parameter int WIDTH        = WIDTH_DEF,
    parameter int CLKS_PER_BIT = CPB_DEF,
    parameter int PARITY_EN    = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rx_in,
    output logic [WIDTH-1:0] data_out,
    output logic             data_valid,
    output logic             parity_err,
    output logic             frame_err,
    output logic             busy
);

    // data_valid is a one-cycle load qualifier with no ready/backpressure:
    // the downstream register must capture data_out in every cycle it is high.
    // parity_err only ever rides along with data_valid; frame_err never does.

    localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [2:0]    BIT_LAST = 3'(WIDTH - 1);

    logic             rx_s;
    state_t           state;
    logic [CW-1:0]    cnt;
    logic [2:0]       bit_idx;
    logic [WIDTH-1:0] shift;
    logic             perr;
    logic             done_ok;
    logic             done_ferr;

    sync_2ff #(
        .WIDTH    (1),
        .RESET_VAL(1'b1)
    ) u_sync (
        .clk(clk),
        .rst(rst),
        .d  (rx_in),
        .q  (rx_s)
    );

    // The stop decision is latched into done_ok/done_ferr and presented on the
    // outputs one cycle later, so busy stays high until the pulse appears.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            bit_idx    <= '0;
            shift      <= '0;
            perr       <= 1'b0;
            done_ok    <= 1'b0;
            done_ferr  <= 1'b0;
            data_out   <= '0;
            data_valid <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            data_valid <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            done_ok    <= 1'b0;
            done_ferr  <= 1'b0;

            if (done_ok) begin
                data_out   <= shift;
                data_valid <= 1'b1;
                parity_err <= perr;
                busy       <= 1'b0;
            end
            if (done_ferr) begin
                frame_err <= 1'b1;
                busy      <= 1'b0;
            end

            cnt <= (cnt == CNT_LAST) ? '0 : cnt + 1'b1;

            unique case (state)
                IDLE: begin
                    cnt <= '0;
                    // A new start edge wins over the clear from a frame that
                    // just ended, so back-to-back frames keep busy asserted.
                    if (!rx_s) begin
                        state <= START;
                        busy  <= 1'b1;
                    end
                end
                START: begin
                    if (cnt == CNT_HALF) begin
                        cnt <= '0;
                        if (!rx_s) begin
                            state   <= DATA;
                            bit_idx <= '0;
                            perr    <= 1'b0;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end
                end
                DATA: begin
                    if (cnt == CNT_LAST) begin
                        shift   <= {rx_s, shift[WIDTH-1:1]};
                        bit_idx <= bit_idx + 3'd1;
                        if (bit_idx == BIT_LAST) begin
                            state <= (PARITY_EN != 0) ? PARITY : STOP;
                        end
                    end
                end
                PARITY: begin
                    if (cnt == CNT_LAST) begin
                        perr  <= rx_s ^ even_parity(shift);
                        state <= STOP;
                    end
                end
                STOP: begin
                    if (cnt == CNT_LAST) begin
                        if (rx_s) begin
                            done_ok <= 1'b1;
                            state   <= IDLE;
                        end else begin
                            done_ferr <= 1'b1;
                            state     <= BREAK;
                        end
                    end
                end
                BREAK: begin
                    cnt <= '0;
                    if (rx_s) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ser6_rx_deser.sv
// Directed bench for ser6_rx_deser: a driver serialises frames and queues the
// expected receive event; a monitor pops and compares each output pulse.
module tb_ser6_rx_deser;
    import ser6_pkg::*;

    localparam int CPB = 4;

    logic       clk;
    logic       rst;
    logic       rx_in;
    logic [5:0] data_out;
    logic       data_valid;
    logic       parity_err;
    logic       frame_err;
    logic       busy;

    // Expected event: {frame_err, parity_err, data_out}
    logic [7:0] exp_q[$];
    logic [5:0] last_good;
    int         n_checks;
    int         n_pass;

    ser6_rx_deser dut (
        .clk       (clk),
        .rst       (rst),
        .rx_in     (rx_in),
        .data_out  (data_out),
        .data_valid(data_valid),
        .parity_err(parity_err),
        .frame_err (frame_err),
        .busy      (busy)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // driver tasks
    task automatic drive_bit(input logic b);
        rx_in = b;
        repeat (CPB) @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        rx_in = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [5:0] d, input logic flip_par, input logic stop);
        logic [8:0] bits;
        bits = {stop, (^d) ^ flip_par, d, 1'b0};
        if (stop) begin
            exp_q.push_back({1'b0, flip_par, d});
            last_good = d;
        end else begin
            exp_q.push_back({1'b1, 1'b0, last_good});
        end
        for (int i = 0; i < 9; i++) drive_bit(bits[i]);
    endtask

    // scoreboard monitor
    always @(negedge clk) begin
        if (!rst && (data_valid || frame_err || parity_err)) begin
            if (exp_q.size() == 0) begin
                check("unexpected_pulse", {23'd0, data_valid, frame_err, parity_err, data_out}, 32'd0);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                check("rx_event", {23'd0, data_valid, frame_err, parity_err, data_out},
                      {23'd0, ~e[7], e});
            end
        end
    end

    initial begin
        int lat;
        int busy_w;
        n_checks  = 0;
        n_pass    = 0;
        last_good = 6'd0;
        rx_in     = 1'b1;
        rst       = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("reset_data_out", 32'(data_out), 32'd0);
        check("reset_data_valid", 32'(data_valid), 32'd0);
        check("reset_parity_err", 32'(parity_err), 32'd0);
        check("reset_frame_err", 32'(frame_err), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        idle(4);

        // 1: back-to-back good frames
        send_frame(6'd63, 1'b0, 1'b1);
        send_frame(6'd21, 1'b0, 1'b1);
        send_frame(6'd34, 1'b0, 1'b1);
        idle(8);

        // 2: inverted parity
        send_frame(6'd21, 1'b1, 1'b1);
        idle(8);

        // 3: framing error then held-low line
        send_frame(6'd34, 1'b0, 1'b0);
        rx_in = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        check("break_busy", 32'(busy), 32'd0);
        check("break_data_out", 32'(data_out), 32'd21);
        idle(8);
        send_frame(6'd42, 1'b0, 1'b1);
        idle(8);

        // 4: one-cycle glitch on idle line
        rx_in = 1'b0;
        @(posedge clk);
        #1;
        rx_in = 1'b1;
        repeat (CPB / 2 + 3) @(posedge clk);
        #1;
        check("glitch_busy", 32'(busy), 32'd0);
        check("glitch_state", 32'(dut.state), 32'(IDLE));
        idle(8);

        // 5: reset during data bit 3 of a frame carrying 63; line then idles
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b1);
        drive_bit(1'b1);
        rx_in = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        last_good = 6'd0;
        check("midreset_data_out", 32'(data_out), 32'd0);
        check("midreset_busy", 32'(busy), 32'd0);
        check("midreset_state", 32'(dut.state), 32'(IDLE));
        idle(50);
        send_frame(6'd5, 1'b0, 1'b1);
        idle(8);

        // 6: latency and busy width
        lat    = 0;
        busy_w = 0;
        fork
            send_frame(6'd13, 1'b0, 1'b1);
            begin
                @(posedge clk);
                for (int k = 0; k < 100; k++) begin
                    @(posedge clk);
                    lat++;
                    #1;
                    if (busy) busy_w++;
                    if (data_valid) break;
                end
            end
        join
        check("latency", 32'(lat), 32'd37);
        check("busy_width", 32'(busy_w), 32'd35);
        idle(20);

        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
